moving_avg_filter: RTL and testbench
====================================

MOVING_AVG_FILTER -- requirements
Module: moving_avg_filter

Interface
REQ-001 Parameter DATA_W, default 24, sample width in bits (signed two's complement).
REQ-002 Parameter LOG2_DEPTH, default 3, window depth DEPTH = 2**LOG2_DEPTH; legal range 1..6.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  one-cycle strobe: in_left/in_right hold a new stereo sample pair.
REQ-006 Port in_left  input  DATA_W  signed left-channel sample.
REQ-007 Port in_right  input  DATA_W  signed right-channel sample.
REQ-008 Port bypass  input  1  1 = pass raw samples to output; 0 = averaged output.
REQ-009 Port clear  input  1  synchronous flush of window and accumulators.
REQ-010 Port out_valid  output  1  one-cycle strobe marking new output pair.
REQ-011 Port out_left  output  DATA_W  signed left-channel result.
REQ-012 Port out_right  output  DATA_W  signed right-channel result.
REQ-013 Port primed  output  1  high once DEPTH samples accepted since last reset/clear.

Function
REQ-014 Each channel SHALL keep a DEPTH-entry circular sample buffer, a write pointer of LOG2_DEPTH bits, and a signed running-sum accumulator of DATA_W+LOG2_DEPTH bits.
REQ-015 Both channels SHALL share one write pointer and one fill counter; channels SHALL never interact arithmetically.
REQ-016 On a cycle with in_valid=1 and clear=0: acc <= acc + in - buf[wptr]; buf[wptr] <= in; wptr <= wptr+1 (wraps DEPTH-1 -> 0).
REQ-017 Averaged result SHALL be the updated accumulator arithmetically shifted right by LOG2_DEPTH (floor toward minus infinity), truncated to DATA_W; no rounding, no per-sample division.
REQ-018 Accumulator width SHALL make overflow impossible; no saturation logic.
REQ-019 Latency: out_valid SHALL pulse exactly 1 cycle after each accepted in_valid, with out_left/out_right valid in that same cycle.
REQ-020 out_left/out_right SHALL hold their last value between out_valid pulses.
REQ-021 in_valid on consecutive cycles SHALL be accepted every cycle (throughput 1 pair/cycle).
REQ-022 Before the window is full, empty entries SHALL read as zero, so output = (sum of accepted samples)/DEPTH.
REQ-023 Fill counter SHALL saturate at DEPTH; primed SHALL rise in the same cycle as the out_valid of the DEPTH-th accepted sample and stay high until reset/clear.
REQ-024 bypass=1 at acceptance: output SHALL be the raw input samples (still 1-cycle latency); buffer, accumulator, pointer and fill counter SHALL still update, so deasserting bypass yields an immediately correct average.
REQ-025 clear=1 SHALL zero all buffer entries, accumulators, pointer, fill counter and primed in one cycle, and SHALL not alter out_left/out_right.
REQ-026 clear and in_valid together: clear wins; sample discarded; out_valid=0 next cycle.
REQ-027 in_valid=0: no state change except out_valid <= 0.

Reset
REQ-028 reset_n=0 at a clock edge SHALL zero all buffer entries, accumulators, wptr, fill counter, primed, out_valid, out_left, out_right.
REQ-029 Reset SHALL take priority over clear and in_valid; a sample presented during reset is discarded.
REQ-030 Reset mid-fill or mid-stream SHALL leave no residue: first post-reset output equals in/DEPTH.

Verification (DATA_W=24, LOG2_DEPTH=3)
REQ-031 Reset, then in_valid every cycle with L=R=256 -> outputs 32,64,96,...,256 then constant 256; primed rises with the 8th output.
REQ-032 Steady at 256, step to 512 -> outputs 288,320,...,512 over 8 samples, then constant 512.
REQ-033 From reset, L=-1 constant, R=8 constant -> first pair (-1,1); after 8 samples (-1,8); channels independent.
REQ-034 in_valid every 3rd cycle -> out_valid exactly 1 cycle after each strobe; outputs hold between strobes; results identical to back-to-back case.
REQ-035 Primed at 256, bypass=1 with input 1000 -> output 1000; bypass=0 on next sample of 1000 -> output (6*256+2*1000)/8 = 442.
REQ-036 Primed at 256, assert clear together with in_valid -> no out_valid, primed=0; next sample 256 -> output 32; repeat with reset_n=0 instead -> same.

Source files
------------

// File: rtl/moving_avg_filter.sv
// Stereo moving-average filter: per-channel circular window with a running sum.
// The average is the running sum arithmetically shifted right by LOG2_DEPTH.
module moving_avg_filter #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_left,
  input  logic signed [DATA_W-1:0] in_right,
  input  logic                     bypass,
  input  logic                     clear,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_left,
  output logic signed [DATA_W-1:0] out_right,
  output logic                     primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = DATA_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = LOG2_DEPTH'(1);
  localparam logic [LOG2_DEPTH:0]   FILL_ONE  = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH:0]   FILL_FULL = (LOG2_DEPTH+1)'(DEPTH);

  logic signed [DATA_W-1:0] sbuf_l [DEPTH];
  logic signed [DATA_W-1:0] sbuf_r [DEPTH];
  logic signed [ACC_W-1:0]  acc_l, acc_r;
  logic [LOG2_DEPTH-1:0]    wptr;
  logic [LOG2_DEPTH:0]      fill;

  logic signed [DATA_W-1:0] old_l, old_r;
  logic signed [ACC_W-1:0]  acc_next_l, acc_next_r;
  logic signed [DATA_W-1:0] avg_l, avg_r;

  // Oldest sample leaves the sum as the new one enters; empty slots hold zero.
  always_comb begin
    old_l      = sbuf_l[wptr];
    old_r      = sbuf_r[wptr];
    acc_next_l = acc_l + {{LOG2_DEPTH{in_left[DATA_W-1]}}, in_left}
                       - {{LOG2_DEPTH{old_l[DATA_W-1]}}, old_l};
    acc_next_r = acc_r + {{LOG2_DEPTH{in_right[DATA_W-1]}}, in_right}
                       - {{LOG2_DEPTH{old_r[DATA_W-1]}}, old_r};
    avg_l      = acc_next_l[ACC_W-1:LOG2_DEPTH];
    avg_r      = acc_next_r[ACC_W-1:LOG2_DEPTH];
  end

  assign primed = (fill == FILL_FULL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sbuf_l[i] <= '0;
        sbuf_r[i] <= '0;
      end
      acc_l     <= '0;
      acc_r     <= '0;
      wptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
    end else if (clear) begin
      // Flush the window but keep the last published outputs.
      for (int i = 0; i < DEPTH; i++) begin
        sbuf_l[i] <= '0;
        sbuf_r[i] <= '0;
      end
      acc_l     <= '0;
      acc_r     <= '0;
      wptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sbuf_l[wptr] <= in_left;
      sbuf_r[wptr] <= in_right;
      acc_l        <= acc_next_l;
      acc_r        <= acc_next_r;
      wptr         <= wptr + PTR_ONE;
      if (fill != FILL_FULL)
        fill <= fill + FILL_ONE;
      out_valid    <= 1'b1;
      out_left     <= bypass ? in_left  : avg_l;
      out_right    <= bypass ? in_right : avg_r;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed self-checking bench for moving_avg_filter (DATA_W=24, LOG2_DEPTH=3).
// Inputs change on falling edges; outputs are sampled on the following falling edge.
module tb_moving_avg_filter;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic signed [23:0] in_left;
  logic signed [23:0] in_right;
  logic               bypass;
  logic               clear;
  logic               out_valid;
  logic signed [23:0] out_left;
  logic signed [23:0] out_right;
  logic               primed;

  int checks   = 0;
  int failures = 0;

  moving_avg_filter #(.DATA_W(24), .LOG2_DEPTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .in_left(in_left), .in_right(in_right), .bypass(bypass), .clear(clear),
    .out_valid(out_valid), .out_left(out_left), .out_right(out_right),
    .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    bypass   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One accepted sample pair; returns at the falling edge where its result is visible.
  task automatic applyStimulus(input logic signed [23:0] l, input logic signed [23:0] r,
                               input logic byp);
    in_left  = l;
    in_right = r;
    bypass   = byp;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  task automatic checkPair(input string tag, input logic signed [31:0] el,
                           input logic signed [31:0] er, input logic ep);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'sd1);
    checkOutput({tag, "_left"}, out_left, el);
    checkOutput({tag, "_right"}, out_right, er);
    checkOutput({tag, "_primed"}, {31'd0, primed}, {31'd0, ep});
  endtask

  task automatic primeWith256();
    resetDut();
    for (int k = 0; k < 8; k++) applyStimulus(24'sd256, 24'sd256, 1'b0);
  endtask

  initial begin
    in_left  = '0;
    in_right = '0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    bypass   = 1'b0;

    // Reset state
    resetDut();
    checkOutput("rst_valid", {31'd0, out_valid}, 32'sd0);
    checkOutput("rst_left", out_left, 32'sd0);
    checkOutput("rst_right", out_right, 32'sd0);
    checkOutput("rst_primed", {31'd0, primed}, 32'sd0);

    // Back-to-back ramp 32..256, then steady
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(24'sd256, 24'sd256, 1'b0);
      checkPair("ramp", (k < 8 ? 32 * k : 256), (k < 8 ? 32 * k : 256), (k >= 8));
    end

    // Step 256 -> 512
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(24'sd512, 24'sd512, 1'b0);
      checkPair("step", (k < 8 ? 256 + 32 * k : 512), (k < 8 ? 256 + 32 * k : 512), 1'b1);
    end

    // Strobe every third cycle; outputs hold between strobes
    resetDut();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(24'sd256, 24'sd256, 1'b0);
      checkPair("slow", 32 * k, 32 * k, (k == 8));
      @(negedge clk);
      checkOutput("slow_gap_valid", {31'd0, out_valid}, 32'sd0);
      checkOutput("slow_gap_hold", out_left, 32 * k);
      @(negedge clk);
    end

    // Independent channels, floor toward minus infinity
    resetDut();
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(-24'sd1, 24'sd8, 1'b0);
      checkPair("indep", -1, (k < 8 ? k : 8), (k >= 8));
    end
    resetDut();
    applyStimulus(-24'sd9, 24'sd7, 1'b0);
    checkPair("floor", -2, 0, 1'b0);

    // Full-scale extremes never overflow the running sum
    resetDut();
    applyStimulus(-24'sd8388608, 24'sd8388607, 1'b0);
    checkPair("ext_first", -1048576, 1048575, 1'b0);
    for (int k = 2; k <= 8; k++) applyStimulus(-24'sd8388608, 24'sd8388607, 1'b0);
    checkPair("ext_full", -8388608, 8388607, 1'b1);

    // Bypass keeps the window updated
    primeWith256();
    applyStimulus(24'sd1000, 24'sd1000, 1'b1);
    checkPair("bypass_on", 1000, 1000, 1'b1);
    applyStimulus(24'sd1000, 24'sd1000, 1'b0);
    checkPair("bypass_off", 442, 442, 1'b1);

    // Clear beats in_valid and leaves outputs alone
    primeWith256();
    in_left  = 24'sd999;
    in_right = 24'sd999;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    checkOutput("clr_valid", {31'd0, out_valid}, 32'sd0);
    checkOutput("clr_primed", {31'd0, primed}, 32'sd0);
    checkOutput("clr_hold", out_left, 32'sd256);
    applyStimulus(24'sd256, 24'sd256, 1'b0);
    checkPair("clr_after", 32, 32, 1'b0);

    // Reset beats in_valid
    primeWith256();
    in_left  = 24'sd999;
    in_right = 24'sd999;
    in_valid = 1'b1;
    reset_n  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    checkOutput("rstmid_valid", {31'd0, out_valid}, 32'sd0);
    checkOutput("rstmid_primed", {31'd0, primed}, 32'sd0);
    checkOutput("rstmid_left", out_left, 32'sd0);
    applyStimulus(24'sd256, 24'sd256, 1'b0);
    checkPair("rstmid_after", 32, 32, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
